// File: rtl/cic_fifo_pkg.sv
// Shared constants and types for the CIC sample FIFO.
package cic_fifo_pkg;
  localparam int ADDR_W_D   = 6;
  localparam int DATA_W_D   = 32;
  localparam int DC_SHIFT_D = 8;

  typedef logic [ADDR_W_D:0]   ptr_t;
  typedef logic [DATA_W_D-1:0] sample_t;
endpackage

// File: rtl/cic_sample_fifo_if.sv
// Sample-in / pop-out / status bundle of the CIC sample FIFO.
interface cic_sample_fifo_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   level;
  logic [ADDR_W:0]   threshold;
  logic              irq;
  logic              overflow;
  logic              ovf_clr;
  logic              flush;

  modport master (
    output in_data, in_valid, rd_en, threshold, ovf_clr, flush,
    input  rd_data, rd_valid, empty, full, level, irq, overflow
  );
  modport slave (
    input  in_data, in_valid, rd_en, threshold, ovf_clr, flush,
    output rd_data, rd_valid, empty, full, level, irq, overflow
  );
endinterface

// File: rtl/cic_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read (read-old on collision).
module cic_fifo_ram #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  // Array kept reset-free so it maps onto block RAM; only the output register resets.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or negedge rst)
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/cic_sample_fifo.sv
// Circular sample buffer behind the PDM CIC decimator with level irq and sticky overflow.
// Define CIC_FIFO_DC_BLOCK_EN to insert a one-stage DC blocker ahead of storage.
module cic_sample_fifo
  import cic_fifo_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_D,
  parameter int DATA_W   = DATA_W_D,
  parameter int DC_SHIFT = DC_SHIFT_D
) (
  input logic             clk,
  input logic             rst,
  cic_sample_fifo_if.slave bus
);
  if (ADDR_W < 1 || DC_SHIFT < 1) begin : g_param_chk
    $error("cic_sample_fifo: ADDR_W and DC_SHIFT must be at least 1");
  end

  logic [ADDR_W:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, level_n;
  logic [ADDR_W:0]   level_q;
  logic              empty_q, full_q, irq_q, ovf_q, rdv_q, ge_q, ge_n;
  logic              wr_req, rd_do, wr_do, drop;
  logic [DATA_W-1:0] wr_sample;

`ifdef CIC_FIFO_DC_BLOCK_EN
  localparam int ACC_W = DATA_W + DC_SHIFT;
  localparam logic signed [DATA_W+1:0] SAT_HI = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W+1:0] SAT_LO = {3'b111, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W+1:0] x_ext, mean, diff;
  logic [DATA_W-1:0]        y_sat, s_data;
  logic                     s_valid;

  // The CIC count is unsigned; two guard bits keep x - mean exact before saturation.
  always_comb begin
    x_ext = {2'b00, bus.in_data};
    mean  = (DATA_W+2)'(acc >>> DC_SHIFT);
    diff  = x_ext - mean;
    y_sat = diff[DATA_W-1:0];
    if (diff > SAT_HI)      y_sat = SAT_HI[DATA_W-1:0];
    else if (diff < SAT_LO) y_sat = SAT_LO[DATA_W-1:0];
  end

  // The tracker follows every sample, including ones later dropped or flushed.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc     <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
    end else begin
      s_valid <= bus.in_valid & ~bus.flush;
      if (bus.in_valid) begin
        acc    <= acc + ACC_W'(diff);
        s_data <= y_sat;
      end
    end

  assign wr_req    = s_valid;
  assign wr_sample = s_data;
`else
  assign wr_req    = bus.in_valid;
  assign wr_sample = bus.in_data;
`endif

  // Empty/full come from registered state, so a write into an empty FIFO cannot feed a same-cycle read.
  always_comb begin
    rd_do    = bus.rd_en & ~empty_q & ~bus.flush;
    wr_do    = wr_req & (~full_q | rd_do) & ~bus.flush;
    drop     = wr_req & full_q & ~rd_do & ~bus.flush;
    wr_ptr_n = bus.flush ? '0 : wr_ptr + (ADDR_W+1)'(wr_do);
    rd_ptr_n = bus.flush ? '0 : rd_ptr + (ADDR_W+1)'(rd_do);
    level_n  = wr_ptr_n - rd_ptr_n;
    ge_n     = (bus.threshold != '0) && (level_n >= bus.threshold);
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ge_q    <= 1'b0;
      irq_q   <= 1'b0;
      ovf_q   <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      level_q <= level_n;
      empty_q <= (level_n == '0);
      full_q  <= level_n[ADDR_W];
      ge_q    <= ge_n;
      irq_q   <= ge_n & ~ge_q;
      ovf_q   <= drop | (ovf_q & ~bus.ovf_clr);
      rdv_q   <= rd_do;
    end

  cic_fifo_ram #(.AW(ADDR_W), .DW(DATA_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_do),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wr_sample),
    .re    (rd_do),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (bus.rd_data)
  );

  assign bus.rd_valid = rdv_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.level    = level_q;
  assign bus.irq      = irq_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_cic_sample_fifo.sv
// Directed + randomized bench for cic_sample_fifo against a queue-based reference model.
module tb_cic_sample_fifo;
  import cic_fifo_pkg::*;

`ifdef CIC_FIFO_DC_BLOCK_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif
  localparam int DSH   = 4;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cic_sample_fifo_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  cic_sample_fifo #(.ADDR_W(6), .DATA_W(32), .DC_SHIFT(DSH)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  sample_t q[$];
  sample_t rdd_m, pend_d;
  bit      rdv_m, ovf_m, irq_m, prev_ab, pend_v;
  longint  acc_m;

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rdd_m = '0; rdv_m = 0; ovf_m = 0; irq_m = 0; prev_ab = 0;
    pend_v = 0; pend_d = '0; acc_m = 0;
  endtask

  // One clock edge of the spec's behaviour, using the inputs currently on the bus.
  task automatic model_step();
    bit      wreq, drop, above;
    sample_t wd;
    longint  y;
    wreq = DC ? pend_v : bus.in_valid;
    wd   = DC ? pend_d : bus.in_data;
    if (DC) begin
      if (bus.in_valid) begin
        y = longint'(bus.in_data) - (acc_m >>> DSH);
        acc_m = acc_m + y;
        if (y > 64'sd2147483647) y = 64'sd2147483647;
        if (y < -64'sd2147483648) y = -64'sd2147483648;
        pend_d = y[31:0];
      end
      pend_v = bus.in_valid && !bus.flush;
    end
    rdv_m = 0;
    drop  = 0;
    if (bus.flush) q.delete();
    else begin
      if (bus.rd_en && q.size() > 0) begin
        rdd_m = q.pop_front();
        rdv_m = 1;
      end
      if (wreq) begin
        if (q.size() < DEPTH) q.push_back(wd);
        else drop = 1;
      end
    end
    ovf_m   = drop | (ovf_m & !bus.ovf_clr);
    above   = (bus.threshold != 0) && (q.size() >= int'(bus.threshold));
    irq_m   = above && !prev_ab;
    prev_ab = above;
  endtask

  task automatic check_all();
    chk("rd_valid", bus.rd_valid, rdv_m);
    chk("rd_data",  bus.rd_data,  rdd_m);
    chk("level",    bus.level,    q.size());
    chk("empty",    bus.empty,    q.size() == 0);
    chk("full",     bus.full,     q.size() == DEPTH);
    chk("irq",      bus.irq,      irq_m);
    chk("overflow", bus.overflow, ovf_m);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_data"},  bus.rd_data,  0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_empty"},    bus.empty,    1);
    chk({tag, "_full"},     bus.full,     0);
    chk({tag, "_level"},    bus.level,    0);
    chk({tag, "_overflow"}, bus.overflow, 0);
    chk({tag, "_irq"},      bus.irq,      0);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input sample_t d, input bit r);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.rd_en    = r;
    cyc();
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 3; i++) drive(1'b0, '0, 1'b1);
  endtask

  int      irq_cnt;
  sample_t last_rd;

  initial begin
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.rd_en     = 1'b0;
    bus.threshold = '0;
    bus.ovf_clr   = 1'b0;
    bus.flush     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // three writes then three reads
    drive(1'b1, 32'd10, 1'b0);
    drive(1'b1, 32'd20, 1'b0);
    drive(1'b1, 32'd30, 1'b0);
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    chk("t1_empty_end", bus.empty, 1);

    // fill past capacity, clear overflow, then write+read at full
    for (int i = 0; i <= 64; i++) drive(1'b1, sample_t'(i), 1'b0);
    drive(1'b0, '0, 1'b0);
    chk("t2_full", bus.full, 1);
    chk("t2_ovf", bus.overflow, 1);
    bus.ovf_clr = 1'b1;
    cyc();
    bus.ovf_clr = 1'b0;
    chk("t2_ovf_clr", bus.overflow, 0);
    drive(1'b1, 32'd999, 1'b1);
    drive(1'b0, '0, 1'b0);
    chk("t3_level", bus.level, 64);
    drain();

    // threshold irq and disabled irq
    for (int t = 0; t < 2; t++) begin
      bus.threshold = (t == 0) ? 7'd4 : 7'd0;
      irq_cnt = 0;
      for (int i = 0; i < 7; i++) begin
        drive(i < 5, sample_t'(100 + i), 1'b0);
        if (bus.irq) irq_cnt++;
      end
      chk("t4_irq_count", irq_cnt, (t == 0) ? 1 : 0);
      drain();
    end
    bus.threshold = '0;

    // flush with a same-cycle write at level 10
    for (int i = 0; i < 10; i++) drive(1'b1, sample_t'(200 + i), 1'b0);
    drive(1'b0, '0, 1'b0);
    bus.flush = 1'b1;
    drive(1'b1, 32'd555, 1'b0);
    bus.flush = 1'b0;
    chk("t5_flush_empty", bus.empty, 1);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1);
    chk("t5_no_rdv", bus.rd_valid, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 31) == 0) bus.threshold = 7'($urandom_range(0, 12));
      bus.flush   = ($urandom_range(0, 63) == 0);
      bus.ovf_clr = ($urandom_range(0, 15) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, (i % 200) > 120 ? 1'b1 : ($urandom_range(0, 2) == 0));
      bus.flush   = 1'b0;
      bus.ovf_clr = 1'b0;
    end

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) drive(1'b1, $urandom, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    model_reset();
    bus.threshold = '0;
    @(negedge clk);
    rst_n = 1'b1;

    if (DC) begin
      for (int i = 0; i < 200; i++) begin
        drive(1'b1, 32'd1000, 1'b1);
        if (bus.rd_valid) last_rd = bus.rd_data;
      end
      for (int i = 0; i < 3; i++) begin
        drive(1'b0, '0, 1'b1);
        if (bus.rd_valid) last_rd = bus.rd_data;
      end
      chk("dc_settle", (signed'(last_rd) >= -1) && (signed'(last_rd) <= 1), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cic_sample_fifo.md
# cic_sample_fifo

Sample buffer directly downstream of the PDM CIC decimator. Captures each one-cycle `in_valid` pulse of the 32-bit CIC output into a circular FIFO, which the processor-side register interface drains. Provides level and threshold interrupt. Tracks overflow with a sticky flag. Optionally removes the DC offset of the CIC output before storage.

## Interface
- `ADDR_W`, default 6: FIFO depth is 2^ADDR_W entries (64).
- `DATA_W`, default 32: sample width; must match the CIC output.
- `DC_SHIFT`, default 8: DC-tracker time constant, 2^DC_SHIFT samples. Only used with the DC blocker.

Ports:
- `clk`, in, 1: system clock, 50 MHz.
- `rst`, in, 1: asynchronous, active-low reset.
- `in_data`, in, DATA_W: CIC output sample.
- `in_valid`, in, 1: one-cycle strobe qualifying `in_data`.
- `rd_en`, in, 1: pop request from the bus side.
- `rd_data`, out, DATA_W: popped sample, registered.
- `rd_valid`, out, 1: one-cycle strobe qualifying `rd_data`.
- `empty`, out, 1: FIFO holds no entries.
- `full`, out, 1: FIFO holds 2^ADDR_W entries.
- `level`, out, ADDR_W+1: current entry count.
- `threshold`, in, ADDR_W+1: interrupt level; 0 disables `irq`.
- `irq`, out, 1: one-cycle pulse when `level` crosses from below `threshold` to at or above it.
- `overflow`, out, 1: sticky, set when a sample is dropped.
- `ovf_clr`, in, 1: clears `overflow`.
- `flush`, in, 1: synchronous FIFO clear.

## Operation
- Write: on an accepted `in_valid`, the sample (or its DC-blocked value) is written at `wr_ptr`, and `wr_ptr` increments modulo 2^ADDR_W.
- Read: on `rd_en` with `!empty`, the entry at `rd_ptr` is registered onto `rd_data`, `rd_valid` pulses, and `rd_ptr` increments modulo depth.
- `rd_en` while empty is ignored: no `rd_valid`, and `rd_data` holds its value.
- Pointers are ADDR_W+1 bits; the MSB distinguishes full from empty. `level = wr_ptr - rd_ptr`.
- Full, write without read: the sample is dropped, `overflow` sets, and the pointers are unchanged.
- Full, write with read in the same cycle: both occur and `level` stays at the maximum.
- Empty, write with read in the same cycle: the read is ignored because `empty` is evaluated before the write.
- `flush`: zeroes both pointers and has priority over any same-cycle write or read. It does not touch `overflow`, `rd_data` or the DC tracker.
- `ovf_clr` and a new overflow in the same cycle: set wins.
- `irq` is computed from the registered `level` of the previous and current cycle. Because of the ≥ comparison, a `threshold` change can produce an immediate pulse.
- Reset values:
  - `rd_data`=0, `rd_valid`=0, `empty`=1, `full`=0, `level`=0, `overflow`=0, `irq`=0.
  - Pointers and the DC accumulator are 0.
  - RAM contents are undefined.
- Reset asserted mid-operation discards all contents immediately (asynchronous).

## Timing
- Write visibility: `in_valid` at cycle n gives `empty`=0 and `level` updated at n+1 without the DC blocker, or n+2 with it.
- Read latency: `rd_en` at cycle n gives `rd_data`/`rd_valid` at n+1, and `level` decrements at n+1.
- Back-to-back `rd_en` every cycle is supported and yields one sample per cycle.
- Status outputs (`empty`, `full`, `level`, `irq`, `overflow`) are registered. They all reflect the same cycle's pointer update.
- Input rate is at most one sample per cycle; the CIC rate is far lower.

## Configuration
- Macro `CIC_FIFO_DC_BLOCK_EN`.
- Defined: adds one pipeline stage computing a DC-removed sample.
  - `acc` is a DATA_W+DC_SHIFT-bit signed register.
  - Output: `y = x - (acc >>> DC_SHIFT)`.
  - Update: `acc += x - (acc >>> DC_SHIFT)`.
  - `y` is stored as signed two's complement, saturated to DATA_W.
  - The accumulator updates only on accepted samples, including dropped-on-full samples, so tracking continues.
- Undefined: the sample is stored unmodified (unsigned CIC count) and write latency is 1.

## Structure
- Package `cic_fifo_pkg`:
  - default ADDR_W, DATA_W and DC_SHIFT constants;
  - pointer typedef (ADDR_W+1 bits);
  - sample typedef.
- Sub-module `cic_fifo_ram`: simple dual-port RAM with synchronous write and registered read, structured for block-RAM inference.
- Top level holds:
  - pointers and status logic;
  - the optional DC stage;
  - irq and overflow logic.

## Test plan
- Reset, then write 3 samples (10, 20, 30) and read 3 → `rd_data` 10, 20, 30 on consecutive `rd_valid`; `level` goes 3→0; `empty`=1 at end.
- Write 65 samples (0..64) with no reads → `full`=1, `level`=64, `overflow`=1; reads return 0..63 (sample 64 dropped). `ovf_clr` → `overflow`=0.
- Full FIFO, `in_valid`+`rd_en` in the same cycle → `level` stays 64, `overflow` stays 0, and the new sample is read last.
- `threshold`=4, write 5 samples → a single `irq` pulse in the cycle `level` becomes 4. `threshold`=0 → no `irq` ever.
- `flush` asserted together with `in_valid` at `level`=10 → `level`=0 and `empty`=1 next cycle; the sample is discarded and `rd_en` gives no `rd_valid`.
- With `CIC_FIFO_DC_BLOCK_EN`, DC_SHIFT=4, constant input 1000 for 200 samples → stored values decay from 1000 toward 0 (within ±1 after 200 samples). Assert `rst` mid-stream → all outputs return to reset values asynchronously.
